// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use interlock, branch
// redirect flushing and data-memory wait handling for a five-stage pipeline.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             bubble_w,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        MEM_WAIT
    } state_t;

    // Register-usage snapshot of the instruction currently in EX.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } ex_shadow_t;

    // Writeback intent of the instructions in MEM and WB.
    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
    } wr_shadow_t;

    localparam int BW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BUSY_MAX  = BW'(TIMEOUT);
    localparam logic [BW-1:0] BUSY_LAST = BW'(TIMEOUT - 1);

    state_t     state_q, state_d;
    ex_shadow_t ex_q;
    wr_shadow_t mem_q, wb_q;
    logic [BW-1:0] busy_cnt;
    logic       load_use;

    // ------------------------------------------------------------------
    // Forwarding: the MEM result is younger than WB, so it wins.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic       use_src,
                                           input logic [4:0] src,
                                           input wr_shadow_t m,
                                           input wr_shadow_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && m.rw && (m.rd != 5'd0) && (m.rd == src))
            sel = 2'b01;
        else if (use_src && w.rw && (w.rd != 5'd0) && (w.rd == src))
            sel = 2'b10;
        return sel;
    endfunction

    assign fwd_a = fwd_sel(ex_q.use1, ex_q.rs1, mem_q, wb_q);
    assign fwd_b = fwd_sel(ex_q.use2, ex_q.rs2, mem_q, wb_q);

    assign load_use = id_valid && ex_q.ld && (ex_q.rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_q.rd)));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        bubble_w = 1'b0;
        unique case (state_q)
            INIT: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                state_d = RUN;
            end
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_e  = 1'b1;
                    stall_m  = 1'b1;
                    bubble_w = 1'b1;
                    state_d  = MEM_WAIT;
                end else begin
                    // The cycle leaving MEM_WAIT is an ordinary RUN cycle.
                    state_d = RUN;
                    if (ex_redirect) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
            end
            default: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                state_d = INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline shadows: a memory wait freezes EX and MEM and drains WB.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; MEM <= EX and WB <= MEM shift correctly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (stall_e) begin
            wb_q <= '0;
        end else begin
            if (flush_e || !id_valid)
                ex_q <= '0;
            else
                ex_q <= '{rs1: id_rs1, rs2: id_rs2, use1: id_use_rs1,
                          use2: id_use_rs2, rd: id_rd, rw: id_regwrite,
                          ld: id_memread};
            mem_q <= '{rd: ex_q.rd, rw: ex_q.rw};
            wb_q  <= mem_q;
        end
    end

    // ------------------------------------------------------------------
    // Statistics and watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_f && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    // stall_m is high exactly on the edges that land in MEM_WAIT, so the
    // count equals the number of consecutive MEM_WAIT cycles so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (!stall_m)
                busy_cnt <= '0;
            else if (busy_cnt != BUSY_MAX)
                busy_cnt <= busy_cnt + BW'(1);
            if (stall_m && (busy_cnt >= BUSY_LAST))
                mem_timeout <= 1'b1;
        end
    end

endmodule
